// File: rtl/mem_io_bridge.sv
// rtl/mem_io_bridge.sv - core data-port bridge to on-chip RAM and memory-mapped IO channels
// Decodes each accepted access to RAM, an IO channel or unmapped space; sticky bus error on fault.
module mem_io_bridge #(
  parameter int          ADDR_W     = 10,
  parameter int          RAM_RD_LAT = 1,
  parameter int          N_IO       = 4,
  parameter logic [31:0] IO_BASE    = 32'hFFFF_FF00,
  parameter int          IO_TMO     = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [31:0]          riscv_addr,
  input  logic [31:0]          riscv_wdata,
  input  logic [3:0]           riscv_wmask,
  input  logic                 riscv_rstrb,
  output logic [31:0]          riscv_rdata,
  output logic                 riscv_rbusy,
  output logic                 riscv_wbusy,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [31:0]          ram_wdata,
  output logic [3:0]           ram_byteena,
  output logic                 ram_wen,
  output logic                 ram_rden,
  input  logic [31:0]          ram_rdata,
  output logic [N_IO-1:0]      io_req,
  output logic                 io_we,
  output logic [1:0]           io_reg,
  output logic [31:0]          io_wdata,
  output logic [3:0]           io_wmask,
  input  logic [32*N_IO-1:0]   io_rdata,
  input  logic [N_IO-1:0]      io_ack,
  input  logic                 err_clr,
  output logic                 bus_err,
  output logic [31:0]          err_addr
);

  localparam int CNT_W = ($clog2(IO_TMO + 1) > 3) ? $clog2(IO_TMO + 1) : 3;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(IO_TMO - 1);
  localparam logic [CNT_W-1:0] LAT_C    = CNT_W'(RAM_RD_LAT);
  localparam logic [4:0]       N_IO_C   = 5'(N_IO);

  typedef enum logic [2:0] {S_IDLE, S_RAM_RD, S_RAM_WR, S_IO_WAIT, S_ERR} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wmask;
  logic              r_we;
  logic [31:0]       r_rdata;
  logic              r_rbusy;
  logic              r_wbusy;
  logic              r_ram_wen;
  logic              r_ram_rden;
  logic [N_IO-1:0]   r_io_req;
  logic              r_bus_err;
  logic [31:0]       r_err_addr;

  logic              w_wr_req;
  logic              w_rd_req;
  logic              w_is_ram;
  logic              w_is_io;
  logic [N_IO-1:0]   w_ch_oh;
  logic              w_ack;
  logic [31:0]       w_io_rd;
  logic              w_err_set;

  assign w_wr_req = |riscv_wmask;
  assign w_rd_req = riscv_rstrb & ~w_wr_req;
  assign w_is_ram = (riscv_addr[31:ADDR_W+2] == '0);
  assign w_is_io  = (riscv_addr[31:8] == IO_BASE[31:8]) && ({1'b0, riscv_addr[7:4]} < N_IO_C);
  assign w_ack    = |(io_ack & r_io_req);

  // The held one-hot request doubles as the read-data slice select.
  always_comb begin
    w_ch_oh = '0;
    w_io_rd = '0;
    for (int k = 0; k < N_IO; k++) begin
      if (riscv_addr[7:4] == 4'(k)) w_ch_oh[k] = 1'b1;
      if (r_io_req[k]) w_io_rd = io_rdata[32*k +: 32];
    end
  end

  assign w_err_set = (r_state == S_ERR) ||
                     ((r_state == S_IO_WAIT) && !w_ack && (r_cnt == TMO_LAST));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_we       <= 1'b0;
      r_rdata    <= '0;
      r_rbusy    <= 1'b0;
      r_wbusy    <= 1'b0;
      r_ram_wen  <= 1'b0;
      r_ram_rden <= 1'b0;
      r_io_req   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_wr_req || w_rd_req) begin
            r_addr  <= riscv_addr;
            r_wdata <= riscv_wdata;
            r_wmask <= riscv_wmask;
            r_we    <= w_wr_req;
            r_cnt   <= '0;
            r_rbusy <= w_rd_req;
            r_wbusy <= w_wr_req;
            if (w_is_ram) begin
              r_ram_wen  <= w_wr_req;
              r_ram_rden <= w_rd_req;
              r_state    <= w_wr_req ? S_RAM_WR : S_RAM_RD;
            end else if (w_is_io) begin
              r_io_req <= w_ch_oh;
              r_state  <= S_IO_WAIT;
            end else begin
              r_state <= S_ERR;
            end
          end
        end
        S_RAM_RD: begin
          r_ram_rden <= 1'b0;
          if (r_cnt == LAT_C) begin
            r_rdata <= ram_rdata;
            r_rbusy <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RAM_WR: begin
          r_ram_wen <= 1'b0;
          r_wbusy   <= 1'b0;
          r_state   <= S_IDLE;
        end
        S_IO_WAIT: begin
          if (w_ack || (r_cnt == TMO_LAST)) begin
            if (!r_we) r_rdata <= w_ack ? w_io_rd : '0;
            r_io_req <= '0;
            r_rbusy  <= 1'b0;
            r_wbusy  <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ERR: begin
          if (!r_we) r_rdata <= '0;
          r_rbusy <= 1'b0;
          r_wbusy <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bus_err  <= 1'b0;
      r_err_addr <= '0;
    end else if (w_err_set) begin
      r_bus_err <= 1'b1;
      if (!r_bus_err) r_err_addr <= r_addr;
    end else if (err_clr) begin
      r_bus_err <= 1'b0;
    end
  end

  assign riscv_rdata = r_rdata;
  assign riscv_rbusy = r_rbusy;
  assign riscv_wbusy = r_wbusy;
  assign ram_addr    = r_addr[ADDR_W+1:2];
  assign ram_wdata   = r_wdata;
  assign ram_byteena = r_wmask;
  assign ram_wen     = r_ram_wen;
  assign ram_rden    = r_ram_rden;
  assign io_req      = r_io_req;
  assign io_we       = r_we;
  assign io_reg      = r_addr[3:2];
  assign io_wdata    = r_wdata;
  assign io_wmask    = r_wmask;
  assign bus_err     = r_bus_err;
  assign err_addr    = r_err_addr;

endmodule

// File: tb/tb_mem_io_bridge.sv
// tb/tb_mem_io_bridge.sv - self-checking bench for mem_io_bridge with RAM model and read scoreboard
module tb_mem_io_bridge;

  localparam int ADDR_W = 10;
  localparam int LAT    = 2;
  localparam int N_IO   = 4;
  localparam int TMO    = 8;

  logic               clk;
  logic               reset_n;
  logic [31:0]        riscv_addr;
  logic [31:0]        riscv_wdata;
  logic [3:0]         riscv_wmask;
  logic               riscv_rstrb;
  logic [31:0]        riscv_rdata;
  logic               riscv_rbusy;
  logic               riscv_wbusy;
  logic [ADDR_W-1:0]  ram_addr;
  logic [31:0]        ram_wdata;
  logic [3:0]         ram_byteena;
  logic               ram_wen;
  logic               ram_rden;
  logic [31:0]        ram_rdata;
  logic [N_IO-1:0]    io_req;
  logic               io_we;
  logic [1:0]         io_reg;
  logic [31:0]        io_wdata;
  logic [3:0]         io_wmask;
  logic [32*N_IO-1:0] io_rdata;
  logic [N_IO-1:0]    io_ack;
  logic               err_clr;
  logic               bus_err;
  logic [31:0]        err_addr;

  mem_io_bridge #(
    .ADDR_W(ADDR_W), .RAM_RD_LAT(LAT), .N_IO(N_IO),
    .IO_BASE(32'hFFFF_FF00), .IO_TMO(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .riscv_addr(riscv_addr), .riscv_wdata(riscv_wdata), .riscv_wmask(riscv_wmask),
    .riscv_rstrb(riscv_rstrb), .riscv_rdata(riscv_rdata), .riscv_rbusy(riscv_rbusy),
    .riscv_wbusy(riscv_wbusy), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_byteena(ram_byteena), .ram_wen(ram_wen), .ram_rden(ram_rden), .ram_rdata(ram_rdata),
    .io_req(io_req), .io_we(io_we), .io_reg(io_reg), .io_wdata(io_wdata), .io_wmask(io_wmask),
    .io_rdata(io_rdata), .io_ack(io_ack), .err_clr(err_clr), .bus_err(bus_err), .err_addr(err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // RAM model: data presented only in the cycle LAT after ram_rden
  logic [31:0] mem [int];
  logic [3:0]  rd_pipe = '0;
  logic [31:0] rd_val  = '0;
  logic [31:0] cur;
  always @(posedge clk) begin
    rd_pipe <= {rd_pipe[2:0], ram_rden};
    if (ram_rden) rd_val <= mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : 32'h0;
    if (ram_wen) begin
      cur = mem.exists(int'(ram_addr)) ? mem[int'(ram_addr)] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (ram_byteena[b]) cur[8*b +: 8] = ram_wdata[8*b +: 8];
      mem[int'(ram_addr)] = cur;
    end
  end
  assign ram_rdata = rd_pipe[LAT-1] ? rd_val : 32'hDEAD_BEEF;
  assign io_rdata  = {32'h3333_0003, 32'hCAFE_F00D, 32'h1111_0001, 32'h0000_A000};

  // Scoreboard: every completed read pops one expected value
  logic prev_rbusy = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) prev_rbusy = 1'b0;
    else begin
      if (prev_rbusy && !riscv_rbusy) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else chk("sb_rdata", riscv_rdata, exp_q.pop_front());
      end
      prev_rbusy = riscv_rbusy;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input logic r);
    riscv_addr  = a;
    riscv_wdata = d;
    riscv_wmask = m;
    riscv_rstrb = r;
  endtask

  task automatic idle_in;
    riscv_wmask = 4'b0;
    riscv_rstrb = 1'b0;
  endtask

  task automatic wait_rbusy(output int n);
    n = 0;
    while (riscv_rbusy && n < 40) begin n++; tick(); end
  endtask

  task automatic wait_wbusy(output int n);
    n = 0;
    while (riscv_wbusy && n < 40) begin n++; tick(); end
  endtask

  int n;

  initial begin
    reset_n = 1'b0; io_ack = '0; err_clr = 1'b0;
    drive(32'h0, 32'h0, 4'b0, 1'b0);
    tick(); tick();
    chk("rst_rbusy", 32'(riscv_rbusy), 32'd0);
    chk("rst_wbusy", 32'(riscv_wbusy), 32'd0);
    chk("rst_strobes", {30'd0, ram_wen, ram_rden}, 32'd0);
    chk("rst_io_req", 32'(io_req), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_rdata", riscv_rdata, 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    reset_n = 1'b1;
    tick();

    // RAM write
    drive(32'h0000_0010, 32'hA5A5_1234, 4'b0011, 1'b0);
    tick(); idle_in();
    chk("wr_wen", 32'(ram_wen), 32'd1);
    chk("wr_wbusy", 32'(riscv_wbusy), 32'd1);
    chk("wr_addr", 32'(ram_addr), 32'd4);
    chk("wr_byteena", 32'(ram_byteena), 32'h3);
    chk("wr_wdata", ram_wdata, 32'hA5A5_1234);
    tick();
    chk("wr_wen_1cyc", 32'(ram_wen), 32'd0);
    chk("wr_wbusy_1cyc", 32'(riscv_wbusy), 32'd0);

    // RAM read, latency 2
    exp_q.push_back(32'h0000_1234);
    drive(32'h0000_0010, 32'h0, 4'b0, 1'b1);
    tick(); idle_in();
    chk("rd_rden", 32'(ram_rden), 32'd1);
    tick();
    chk("rd_rden_1cyc", 32'(ram_rden), 32'd0);
    wait_rbusy(n);
    chk("rd_busy_cycles", 32'(n + 1), 32'd3);
    chk("rd_rdata", riscv_rdata, 32'h0000_1234);

    // Write wins when rstrb and wmask arrive together
    drive(32'h0000_0020, 32'h1122_3344, 4'b1111, 1'b1);
    tick(); idle_in();
    chk("both_wen", 32'(ram_wen), 32'd1);
    chk("both_no_rd", {30'd0, ram_rden, riscv_rbusy}, 32'd0);
    tick();
    chk("both_rdata_kept", riscv_rdata, 32'h0000_1234);

    // IO read channel 2 reg 1, ack after 5 cycles
    exp_q.push_back(32'hCAFE_F00D);
    drive(32'hFFFF_FF24, 32'h0, 4'b0, 1'b1);
    tick(); idle_in();
    chk("io_rd_req", 32'(io_req), 32'h4);
    chk("io_rd_reg", 32'(io_reg), 32'd1);
    chk("io_rd_we", 32'(io_we), 32'd0);
    chk("io_rd_rbusy", 32'(riscv_rbusy), 32'd1);
    tick(); io_ack = 4'b0001;
    tick(); io_ack = 4'b0000;
    chk("io_foreign_ack", 32'(io_req), 32'h4);
    drive(32'h0000_0030, 32'h9999_9999, 4'b1111, 1'b0);
    tick(); idle_in();
    chk("busy_req_ignored", 32'(ram_wen), 32'd0);
    tick();
    tick(); io_ack = 4'b0100;
    chk("io_rd_busy_at_ack", 32'(riscv_rbusy), 32'd1);
    tick(); io_ack = 4'b0000;
    chk("io_rd_req_drop", 32'(io_req), 32'd0);
    chk("io_rd_rbusy_fall", 32'(riscv_rbusy), 32'd0);
    chk("io_rd_rdata", riscv_rdata, 32'hCAFE_F00D);

    // IO read channel 3 reg 3, ack in first wait cycle
    exp_q.push_back(32'h3333_0003);
    drive(32'hFFFF_FF3C, 32'h0, 4'b0, 1'b1);
    tick(); idle_in(); io_ack = 4'b1000;
    chk("io3_req", 32'(io_req), 32'h8);
    chk("io3_reg", 32'(io_reg), 32'd3);
    tick(); io_ack = 4'b0000;
    chk("io3_done", 32'(riscv_rbusy), 32'd0);

    // IO write channel 1 with no ack: timeout
    drive(32'hFFFF_FF10, 32'h0BAD_CAFE, 4'b1111, 1'b0);
    tick(); idle_in();
    chk("tmo_req", 32'(io_req), 32'h2);
    chk("tmo_we", 32'(io_we), 32'd1);
    chk("tmo_wdata", io_wdata, 32'h0BAD_CAFE);
    chk("tmo_wbusy", 32'(riscv_wbusy), 32'd1);
    n = 0;
    while (io_req != '0 && n < 40) begin n++; tick(); end
    chk("tmo_cycles", 32'(n), 32'(TMO));
    chk("tmo_wbusy_fall", 32'(riscv_wbusy), 32'd0);
    chk("tmo_bus_err", 32'(bus_err), 32'd1);
    chk("tmo_err_addr", err_addr, 32'hFFFF_FF10);
    chk("tmo_rdata_kept", riscv_rdata, 32'h3333_0003);
    err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    chk("clr_bus_err", 32'(bus_err), 32'd0);

    // Unmapped read
    exp_q.push_back(32'h0);
    drive(32'h8000_0000, 32'h0, 4'b0, 1'b1);
    tick(); idle_in();
    chk("um_strobes", {27'd0, io_req, ram_wen}, 32'd0);
    chk("um_rden", 32'(ram_rden), 32'd0);
    wait_rbusy(n);
    chk("um_busy_cycles", 32'(n), 32'd1);
    chk("um_rdata", riscv_rdata, 32'd0);
    chk("um_bus_err", 32'(bus_err), 32'd1);
    chk("um_err_addr", err_addr, 32'h8000_0000);

    // Channel beyond N_IO is unmapped; first error address is kept
    drive(32'hFFFF_FF50, 32'h1, 4'b0001, 1'b0);
    tick(); idle_in();
    chk("ch5_no_req", 32'(io_req), 32'd0);
    wait_wbusy(n);
    chk("ch5_busy_cycles", 32'(n), 32'd1);
    chk("ch5_err_addr_kept", err_addr, 32'h8000_0000);

    // err_clr coincident with a new error: error wins
    err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    exp_q.push_back(32'h0);
    drive(32'hFFFF_FF80, 32'h0, 4'b0, 1'b1);
    tick(); idle_in(); err_clr = 1'b1;
    tick(); err_clr = 1'b0;
    chk("clr_vs_err", 32'(bus_err), 32'd1);
    chk("clr_vs_err_addr", err_addr, 32'hFFFF_FF80);

    // Reset in the middle of an IO access
    drive(32'hFFFF_FF00, 32'h55, 4'b1111, 1'b0);
    tick(); idle_in();
    chk("rst_mid_req", 32'(io_req), 32'h1);
    tick(); tick();
    reset_n = 1'b0;
    #1;
    chk("rst_mid_req_drop", 32'(io_req), 32'd0);
    chk("rst_mid_wbusy", 32'(riscv_wbusy), 32'd0);
    chk("rst_mid_bus_err", 32'(bus_err), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    exp_q.push_back(32'h1122_3344);
    drive(32'h0000_0020, 32'h0, 4'b0, 1'b1);
    tick(); idle_in();
    wait_rbusy(n);
    chk("post_rst_busy", 32'(n), 32'd3);
    chk("post_rst_rdata", riscv_rdata, 32'h1122_3344);

    tick(); tick();
    chk("sb_left", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
